// File: rtl/fnd_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver: latches one-hot decimal codes,
// scans them onto a shared segment bus with anti-ghost blanking and per-digit blink.
module fnd_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 16,
    parameter int BLINK_FRAMES   = 100,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [10*NUM_DIGITS-1:0] number,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              fnd,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    err
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [PW-1:0]         PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0]         FRAME_LAST = FW'(BLINK_FRAMES - 1);

    // Patterns are built active-low and inverted at the output when needed.
    function automatic logic [6:0] seg_encode(input logic [9:0] code);
        logic [6:0] pat;
        case (code)
            10'b0000000001: pat = 7'b1000000;
            10'b0000000010: pat = 7'b1111001;
            10'b0000000100: pat = 7'b0100100;
            10'b0000001000: pat = 7'b0110000;
            10'b0000010000: pat = 7'b0011001;
            10'b0000100000: pat = 7'b0010010;
            10'b0001000000: pat = 7'b0000010;
            10'b0010000000: pat = 7'b1111000;
            10'b0100000000: pat = 7'b0000000;
            10'b1000000000: pat = 7'b0010000;
            default:        pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    logic [9:0]            digit_in [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] multi_hot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_in[gi]  = number[10*gi +: 10];
            // Clearing the lowest set bit leaves something only if >=2 bits were set.
            assign multi_hot[gi] = |(digit_in[gi] & (digit_in[gi] - 10'd1));
        end
    endgenerate

    logic [PW-1:0]         pre_q, pre_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [FW-1:0]         frame_q, frame_d;
    logic                  phase_q, phase_d;
    logic [9:0]            shadow_q [NUM_DIGITS];
    logic [9:0]            shadow_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic                  err_q, err_d;
    logic [6:0]            fnd_q, fnd_d;
    logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;

    logic [6:0]            seg_al;
    logic [NUM_DIGITS-1:0] dig_onehot;

    always_comb begin
        pre_d    = pre_q + PW'(1);
        idx_d    = idx_q;
        frame_d  = frame_q;
        phase_d  = phase_q;
        shadow_d = shadow_q;
        mask_d   = mask_q;
        err_d    = err_q;

        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                if (frame_q == FRAME_LAST) begin
                    frame_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    frame_d = frame_q + FW'(1);
                end
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end

        if (load) begin
            shadow_d = digit_in;
            mask_d   = blink_mask;
            err_d    = |multi_hot;
        end

        // Outputs are computed from pre-edge state so segments and enable always agree.
        seg_al = seg_encode(shadow_q[idx_q]);
        if (phase_q && mask_q[idx_q]) begin
            seg_al = 7'h7F;
        end
        fnd_d = (SEG_ACTIVE_LOW != 0) ? seg_al : ~seg_al;

        dig_onehot = NUM_DIGITS'(1) << idx_q;
        if (int'(pre_q) < BLANK_CYC) begin
            dig_sel_d = DIG_OFF;
        end else begin
            dig_sel_d = (DIG_ACTIVE_LOW != 0) ? ~dig_onehot : dig_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q     <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            phase_q   <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                shadow_q[k] <= '0;
            end
            mask_q    <= '0;
            err_q     <= 1'b0;
            fnd_q     <= SEG_OFF;
            dig_sel_q <= DIG_OFF;
        end else begin
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            phase_q   <= phase_d;
            shadow_q  <= shadow_d;
            mask_q    <= mask_d;
            err_q     <= err_d;
            fnd_q     <= fnd_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign fnd     = fnd_q;
    assign dig_sel = dig_sel_q;
    assign err     = err_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Bench for fnd_scan_driver: directed steps plus random loads, checked every cycle
// against an arithmetic model of the scan timeline.
module tb_fnd_scan_driver;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BC = 1;
    localparam int BF = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           load = 1'b0;
    logic [10*N-1:0] number = '0;
    logic [N-1:0]   blink_mask = '0;
    logic [6:0]     fnd;
    logic [N-1:0]   dig_sel;
    logic           err;

    fnd_scan_driver #(
        .NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .number(number),
        .blink_mask(blink_mask), .fnd(fnd), .dig_sel(dig_sel), .err(err)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: elapsed scan ticks since reset plus the latched display contents.
    int         m_cnt = 0;
    logic [9:0] m_code [N];
    logic [N-1:0] m_mask = '0;
    logic       m_err = 1'b0;
    logic [6:0] pat_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [6:0] model_seg(input logic [9:0] code);
        if ($countones(code) != 1) return 7'h7F;
        for (int j = 0; j < 10; j++) begin
            if (code[j]) return pat_tbl[j];
        end
        return 7'h7F;
    endfunction

    function automatic logic [9:0] oh(input int d);
        logic [9:0] v;
        v = 10'd1 << d;
        return v;
    endfunction

    function automatic logic [39:0] pack4(input int d3, input int d2, input int d1, input int d0);
        return {oh(d3), oh(d2), oh(d1), oh(d0)};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: apply inputs, predict outputs from pre-edge model state, update model, compare.
    task automatic cycle(input logic r, input logic l, input logic [39:0] num, input logic [3:0] msk);
        logic [6:0] ef;
        logic [3:0] ed;
        logic       ee;
        int pre, idx, phase;
        rst = r; load = l; number = num; blink_mask = msk;
        if (r) begin
            ef = 7'h7F; ed = 4'hF; ee = 1'b0;
            m_cnt = 0; m_mask = '0; m_err = 1'b0;
            for (int k = 0; k < N; k++) m_code[k] = '0;
            $display("[TB] t=%0t reset%s", $time, l ? " with load (dropped)" : "");
        end else begin
            pre   = m_cnt % SD;
            idx   = (m_cnt / SD) % N;
            phase = (m_cnt / (SD * N * BF)) % 2;
            ef = model_seg(m_code[idx]);
            if (phase == 1 && m_mask[idx]) ef = 7'h7F;
            ed = (pre < BC) ? 4'hF : ~(4'd1 << idx);
            if (l) begin
                m_err = 1'b0;
                for (int k = 0; k < N; k++) begin
                    m_code[k] = num[10*k +: 10];
                    if ($countones(m_code[k]) >= 2) m_err = 1'b1;
                end
                m_mask = msk;
                $display("[TB] t=%0t load number=%h mask=%b", $time, num, msk);
            end
            ee = m_err;
            m_cnt++;
        end
        @(posedge clk);
        #1;
        check("fnd", {1'b0, fnd}, {1'b0, ef});
        check("dig_sel", {4'b0, dig_sel}, {4'b0, ed});
        check("err", {7'b0, err}, {7'b0, ee});
        check("one_enable", 8'($countones(~dig_sel) <= 1), 8'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, number, blink_mask);
    endtask

    initial begin
        logic [39:0] rnum;
        logic [39:0] base;
        int guard;

        for (int k = 0; k < N; k++) m_code[k] = '0;

        // Reset held three cycles, then release; first enable appears on the second edge.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, '0);
        idle(3);

        // Scan and encode 9,7,1,0.
        cycle(1'b0, 1'b1, pack4(9, 7, 1, 0), 4'b0000);
        idle(36);

        // Multi-hot digit 1 and empty digit 2, then a clean reload.
        base = pack4(4, 0, 0, 6);
        base[19:10] = 10'b0000000011;
        base[29:20] = 10'b0;
        cycle(1'b0, 1'b1, base, 4'b0000);
        idle(20);
        cycle(1'b0, 1'b1, pack4(3, 8, 6, 2), 4'b0000);
        idle(8);

        // Blink digit 0 showing 5 over several frames.
        cycle(1'b0, 1'b1, pack4(1, 2, 3, 5), 4'b0001);
        idle(80);

        // Change digit 2 from 2 to 8 in the middle of its slot.
        cycle(1'b0, 1'b1, pack4(0, 2, 4, 6), 4'b0000);
        guard = 0;
        while (!(((m_cnt / SD) % N) == 2 && (m_cnt % SD) == 1) && guard < 64) begin
            idle(1);
            guard++;
        end
        check("midslot_reach", 8'(guard < 64), 8'd1);
        cycle(1'b0, 1'b1, pack4(0, 8, 4, 6), 4'b0000);
        idle(6);

        // Reset with a simultaneous load while digit 2 is scanned.
        guard = 0;
        while (((m_cnt / SD) % N) != 2 && guard < 64) begin
            idle(1);
            guard++;
        end
        check("rst_reach", 8'(guard < 64), 8'd1);
        cycle(1'b1, 1'b1, pack4(5, 5, 5, 5), 4'b1111);
        idle(12);

        // Random loads, masks, odd codes and occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) == 0) begin
                cycle(1'b1, $urandom_range(1) == 1, number, blink_mask);
            end else if ($urandom_range(11) == 0) begin
                for (int k = 0; k < N; k++) begin
                    if ($urandom_range(9) == 0) rnum[10*k +: 10] = 10'($urandom());
                    else rnum[10*k +: 10] = oh(int'($urandom_range(9)));
                end
                cycle(1'b0, 1'b1, rnum, 4'($urandom()));
            end else begin
                idle(1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fnd_scan_driver.md
Name: fnd_scan_driver

Overview:
Time-multiplexed multi-digit 7-segment (FND) driver, the parametrised successor to the single-digit one-hot FND encoder. It latches NUM_DIGITS one-hot decimal codes on a load strobe and scans one digit at a time onto a shared segment bus. It adds anti-ghosting blanking, per-digit blink, invalid-code detection and configurable output polarity. It sits between datapath/status logic and the board's FND pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
SCAN_DIV, 50000, clk cycles per digit slot (>=2)
BLANK_CYC, 16, cycles at start of each slot with all digit enables inactive (< SCAN_DIV)
BLINK_FRAMES, 100, full scan frames per blink phase toggle (>=1)
SEG_ACTIVE_LOW, 1, 1: segment lit = 0; 0: segment lit = 1
DIG_ACTIVE_LOW, 1, 1: digit enabled = 0; 0: digit enabled = 1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
load  in  1  capture number and blink_mask at this clock edge
number  in  10*NUM_DIGITS  digit k one-hot code at [10k+9:10k]; bit j set = decimal j; digit 0 rightmost
blink_mask  in  NUM_DIGITS  bit k=1: digit k blinks
fnd  out  7  segment bus {g,f,e,d,c,b,a}
dig_sel  out  NUM_DIGITS  digit enables, bit k drives digit k
err  out  1  last loaded value contains a multi-hot code

Behaviour:
- One clock, synchronous active-high reset. Reset clears shadow (all codes 0), mask 0, pre=0, idx=0, frame count 0, phase 0, err 0. fnd = all segments off (7'h7F when SEG_ACTIVE_LOW). dig_sel = all inactive (all 1s when DIG_ACTIVE_LOW). Reset mid-scan restarts scanning from digit 0.
- Shadow: on load=1, number is captured into the shadow register and blink_mask into the mask register. err is set to 1 if any digit code has >=2 bits set, else 0. err holds until the next load. Without load, inputs are ignored.
- Encoding, active-low form, bit6..bit0: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. All-zero code or multi-hot code gives blank (1111111). If SEG_ACTIVE_LOW=0, all patterns are bitwise inverted.
- Prescaler pre counts 0..SCAN_DIV-1. At pre==SCAN_DIV-1, pre wraps to 0 and idx advances (NUM_DIGITS-1 wraps to 0).
- Frame/blink: when idx wraps NUM_DIGITS-1 -> 0, the frame count increments. When it reaches BLINK_FRAMES-1 it clears and phase toggles.
- Outputs are registered; each edge samples the pre/idx/shadow/mask/phase values current before that edge:
  - fnd gets the encoding of shadow digit idx. It is forced blank if phase=1 and mask[idx]=1.
  - dig_sel gets all inactive if pre<BLANK_CYC, else one-hot(idx) with only bit idx active.
  - Latency: outputs lag counters by exactly 1 cycle. A load at edge n is visible on fnd from edge n+1 (the first output update after capture). Output patterns are never mixes of old and new values.
- Exactly one or zero dig_sel bits are active at any time. A digit is never enabled while fnd shows another digit's pattern.
- Load simultaneous with slot change: the new slot uses the newly captured shadow on the following output update; no special case.
- rst and load in the same cycle: rst wins and the load is dropped.

Test Plan:
- Reset: NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2. Hold rst 3 cycles -> fnd=7F, dig_sel=4'hF, err=0. Release -> first dig_sel=4'hE appears 2 cycles later.
- Scan/encode: load number with digits 3..0 = 9,7,1,0 (one-hot) -> per 4-cycle slot, fnd=40/dig_sel=E, then 79/D, then 78/B, then 10/7, repeating. The first cycle of each slot has dig_sel=F.
- Invalid/blank: load digit 1 = 10'b0000000011 and digit 2 = 0 -> err=1; those slots show fnd=7F. Reload all valid -> err=0.
- Blink: mask=4'b0001 with digit 0=5 -> digit 0 slot shows 12 for 2 frames, then 7F for 2 frames, alternating. Other digits are unaffected.
- Load mid-slot: change digit 2 from 2 to 8 during the digit-2 slot -> fnd goes 24 to 00 exactly one cycle after the load edge, with no other transitional value.
- Reset mid-scan at idx=2, and rst+load together -> outputs go to reset values next edge; the shadow is not updated; scanning restarts at digit 0.
